// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: multi-channel LED sequencer.
// A shared prescaler emits a one-cycle tick every TICK_DIV cycles. Each channel
// runs independently in OFF, ON, BLINK or BURST mode and is configured through
// a single-cycle write port. BURST channels fall back to OFF after the
// programmed number of on/off cycles and flag completion on done.
module led_blink_ctrl #(
  parameter int          CH_NUM   = 4,
  parameter int          CH_W     = 2,
  parameter logic [24:0] TICK_DIV = 25'd25_000_000,
  parameter int          PER_W    = 8,
  parameter int          CNT_W    = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [CH_NUM-1:0] led_out,
  output logic [CH_NUM-1:0] busy,
  output logic [CH_NUM-1:0] done
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  localparam int                TCNT_W    = $clog2(TICK_DIV);
  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(TICK_DIV - 25'd1);

  logic [TCNT_W-1:0] r_tick_cnt;
  logic              r_tick;
  logic              w_tick_wrap;

  // Zero period/count would never terminate; they are promoted to 1 on load.
  logic [PER_W-1:0]  w_per_ld;
  logic [CNT_W-1:0]  w_cnt_ld;
  mode_t             w_mode_ld;

  assign w_tick_wrap = (r_tick_cnt == TICK_LAST);
  assign w_per_ld    = (cfg_period == '0) ? PER_W'(1) : cfg_period;
  assign w_cnt_ld    = (cfg_count == '0) ? CNT_W'(1) : cfg_count;
  assign w_mode_ld   = mode_t'(cfg_mode);

  // Free-running prescaler; tick is registered so it lands the cycle after the wrap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick     <= w_tick_wrap;
      r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : ch_g
    mode_t            r_mode;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_ph_cnt;
    logic [CNT_W-1:0] r_rem;
    logic             r_led;
    logic             r_busy;
    logic             r_done;
    logic             w_wr_hit;
    logic             w_run;
    logic             w_ph_end;

    // Channel indices beyond CH_NUM never match, so such writes are dropped.
    assign w_wr_hit = cfg_wr && (cfg_ch == CH_W'(g));
    assign w_run    = (r_mode == MODE_BLINK) || (r_mode == MODE_BURST);
    assign w_ph_end = (r_ph_cnt == r_period - 1'b1);

    // Per-channel sequencer: a write always beats a coincident tick on this channel.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_mode   <= MODE_OFF;
        r_period <= '0;
        r_ph_cnt <= '0;
        r_rem    <= '0;
        r_led    <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        r_done <= 1'b0;
        if (w_wr_hit) begin
          r_mode   <= w_mode_ld;
          r_period <= w_per_ld;
          r_rem    <= w_cnt_ld;
          r_ph_cnt <= '0;
          r_led    <= (w_mode_ld != MODE_OFF);
          r_busy   <= (w_mode_ld == MODE_BLINK) || (w_mode_ld == MODE_BURST);
        end else if (r_tick && w_run) begin
          if (w_ph_end) begin
            r_ph_cnt <= '0;
            if ((r_mode == MODE_BURST) && r_led) begin
              // Falling edge of a burst cycle: count it, finish on the last one.
              r_led <= 1'b0;
              if (r_rem == CNT_W'(1)) begin
                r_mode <= MODE_OFF;
                r_busy <= 1'b0;
                r_done <= 1'b1;
              end else begin
                r_rem <= r_rem - 1'b1;
              end
            end else begin
              r_led <= ~r_led;
            end
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
      end
    end

    assign led_out[g] = r_led;
    assign busy[g]    = r_busy;
    assign done[g]    = r_done;
  end

endmodule
